imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: byte-address width of instruction memory (depth 2^ADDRESS_WIDTH bytes).
REQ-002 Parameter DATA_WIDTH, default 32: fetched instruction width; fixed at 4 bytes.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  loader byte stream: byte present.
REQ-006 in_data  input  8  loader byte stream: byte value.
REQ-007 in_ready  output  1  loader accepts byte this cycle.
REQ-008 PC  input  ADDRESS_WIDTH  fetch byte address from the PC register.
REQ-009 instr  output  DATA_WIDTH  instruction word at PC.
REQ-010 cpu_rst  output  1  active-high hold-in-reset to pcreg/CPU.
REQ-011 load_done  output  1  image fully loaded.
REQ-012 load_err  output  1  sticky header error.

Function
REQ-013 Transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_data SHALL be ignored otherwise.
REQ-014 FSM states SHALL be LEN, LOAD, DONE, ERR; reset state LEN.
REQ-015 LEN: first accepted byte is word count N; N=0 -> DONE; 1<=N<=MAX_WORDS (2^ADDRESS_WIDTH/4 = 64) -> LOAD; N>MAX_WORDS -> ERR.
REQ-016 LOAD: accepted bytes SHALL be written to byte address 0,1,2,... in order, one byte per transfer, written on the accepting edge.
REQ-017 Byte counter SHALL be ADDRESS_WIDTH+1 bits; total expected = 4*N; on the edge accepting byte 4*N-1, FSM -> DONE.
REQ-018 in_ready SHALL be 1 in LEN and LOAD, 0 in DONE and ERR; bytes offered in DONE/ERR SHALL not alter memory.
REQ-019 cpu_rst SHALL be 1 in LEN, LOAD, ERR; 0 only in DONE (registered, deasserts the cycle after the final transfer).
REQ-020 load_done SHALL equal (state==DONE); load_err SHALL equal (state==ERR).
REQ-021 DONE and ERR SHALL be terminal; exit only via rst.
REQ-022 instr SHALL be combinational, little-endian: {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}, address arithmetic modulo 2^ADDRESS_WIDTH (wrap at top).
REQ-023 Fetch port SHALL be readable in every state; a write and a read to the same byte in one cycle SHALL return the old value until the edge.
REQ-024 in_valid held high with in_ready low SHALL cause no state change (backpressure, no drop of the held byte).

Reset
REQ-025 rst=0 SHALL asynchronously force state LEN, byte counter 0, word count 0, cpu_rst=1, load_done=0, load_err=0, in_ready=1.
REQ-026 Memory contents SHALL NOT be reset; reset mid-LOAD restarts at LEN and the next image overwrites from address 0.
REQ-027 After rst rises, the first transfer SHALL be accepted no earlier than the next rising edge.

Structure
REQ-028 Package imem_loader_pkg SHALL hold the state enum (LEN, LOAD, DONE, ERR) and MAX_WORDS constant.
REQ-029 Byte storage SHALL be a sub-module imem_ram: one synchronous byte write port, one combinational 4-byte little-endian read port with wrap.
REQ-030 imem_loader SHALL contain only FSM, counters and handshake logic around imem_ram.

Verification
REQ-031 Load N=2, bytes 13 00 00 00 93 00 10 00 -> in_ready drops after 9th byte, load_done=1, cpu_rst=0; PC=0 -> instr=0x00000013, PC=4 -> instr=0x00100093.
REQ-032 Header N=0x41 (65) -> load_err=1, in_ready=0, cpu_rst=1; subsequent bytes ignored, instr at PC=0 unchanged.
REQ-033 Header N=0 -> load_done=1 next cycle, no memory writes.
REQ-034 N=64 full image with mem[255]=0xAA, mem[0..2]=0x11,0x22,0x33 -> PC=0xFF gives instr=0x332211AA (wrap).
REQ-035 Gap in_valid low for 5 cycles mid-LOAD -> byte counter holds; image identical to gapless load.
REQ-036 rst pulse low after 3 payload bytes of N=1 -> state LEN, cpu_rst=1; reload N=1 bytes EF BE AD DE -> PC=0 gives 0xDEADBEEF.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// This package holds the loader FSM states and the image-size limit.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LEN,
    LOAD,
    DONE,
    ERR
  } load_state_e;

  // Largest image, in 32-bit words, that fits a memory of 2^addr_width bytes.
  function automatic int max_words(input int addr_width);
    return (1 << addr_width) / 4;
  endfunction

  localparam int MAX_WORDS = max_words(8);

endpackage

// File: rtl/imem_ram.sv
// Byte-wide instruction storage with one synchronous write port.
// It also has a combinational 4-byte little-endian read port that wraps at the top.
module imem_ram #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [31:0]              rd_data
);

  logic [7:0]               mem_q [2**ADDRESS_WIDTH];
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic [ADDRESS_WIDTH-1:0] addr3;

  // Contents are intentionally not reset so an image survives a CPU restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Address arithmetic is ADDRESS_WIDTH bits wide, so it wraps at the top.
  always_comb begin
    addr1   = rd_addr + ADDRESS_WIDTH'(1);
    addr2   = rd_addr + ADDRESS_WIDTH'(2);
    addr3   = rd_addr + ADDRESS_WIDTH'(3);
    rd_data = {mem_q[addr3], mem_q[addr2], mem_q[addr1], mem_q[rd_addr]};
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory.
// The CPU is held in reset until the whole image has arrived.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     cpu_rst,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;
  localparam int WC_W  = ADDRESS_WIDTH - 1;
  localparam int MAX_W = max_words(ADDRESS_WIDTH);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0] last_byte;
  logic             xfer;
  logic             wr_en;
  logic [31:0]      rd_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == LEN) || (state_q == LOAD);
    xfer       = in_valid && in_ready;
    last_byte  = {word_cnt_q, 2'b00} - CNT_W'(1);
    wr_en      = (state_q == LOAD) && xfer;
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;

    unique case (state_q)
      LEN: begin
        if (xfer) begin
          byte_cnt_d = '0;
          if (in_data == 8'd0) begin
            state_d = DONE;
          end else if ({24'd0, in_data} > 32'(MAX_W)) begin
            state_d = ERR;
          end else begin
            word_cnt_d = WC_W'(in_data);
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == last_byte) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN;
    endcase

    // Registered so the CPU leaves reset the cycle after the final byte.
    cpu_rst_d = (state_d != DONE);
  end

  assign cpu_rst   = cpu_rst_q;
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);
  assign instr     = DATA_WIDTH'(rd_word);

  imem_ram #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(byte_cnt_q[ADDRESS_WIDTH-1:0]),
    .wr_data(in_data),
    .rd_addr(PC),
    .rd_data(rd_word)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// It uses a vector table for the basic load and hand-written multi-cycle sequences for the rest.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  PC;
  logic [31:0] instr;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int tests_run;
  int fail_count;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [3:0] exp_flags;
  } vec_t;

  imem_loader #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH   (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .PC       (PC),
    .instr    (instr),
    .cpu_rst  (cpu_rst),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input int i);
    case (i)
      0:       return 8'h11;
      1:       return 8'h22;
      2:       return 8'h33;
      255:     return 8'hAA;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  function automatic logic [31:0] full_word(input int pc);
    return {byte_of((pc + 3) % 256), byte_of((pc + 2) % 256),
            byte_of((pc + 1) % 256), byte_of(pc % 256)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Flags packed as {in_ready, load_done, load_err, cpu_rst}.
  task automatic check_flags(input string name, input logic [3:0] expected);
    check_output(name, {28'd0, in_ready, load_done, load_err, cpu_rst}, {28'd0, expected});
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] data);
    @(negedge clk);
    in_valid = valid;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_instr(input string name, input logic [7:0] pc,
                             input logic [31:0] expected);
    PC = pc;
    #1;
    check_output(name, instr, expected);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    PC         = 8'h00;

    vecs[0]  = '{1'b1, 8'h02, 4'b1001};
    vecs[1]  = '{1'b1, 8'h13, 4'b1001};
    vecs[2]  = '{1'b1, 8'h00, 4'b1001};
    vecs[3]  = '{1'b0, 8'h77, 4'b1001};
    vecs[4]  = '{1'b1, 8'h00, 4'b1001};
    vecs[5]  = '{1'b1, 8'h00, 4'b1001};
    vecs[6]  = '{1'b1, 8'h93, 4'b1001};
    vecs[7]  = '{1'b1, 8'h00, 4'b1001};
    vecs[8]  = '{1'b1, 8'h10, 4'b1001};
    vecs[9]  = '{1'b1, 8'h00, 4'b0100};
    vecs[10] = '{1'b1, 8'hFF, 4'b0100};
    vecs[11] = '{1'b0, 8'h00, 4'b0100};

    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_flags", 4'b1001);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      check_flags($sformatf("vec%0d_flags", i), vecs[i].exp_flags);
    end
    check_instr("n2_pc0", 8'h00, 32'h00000013);
    check_instr("n2_pc4", 8'h04, 32'h00100093);
    check_instr("n2_pc2", 8'h02, 32'h00930000);

    do_reset();
    apply_stimulus(1'b1, 8'h41);
    check_flags("hdr65_err", 4'b0011);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'h55);
    end
    check_flags("err_sticky", 4'b0011);
    check_instr("err_mem_intact", 8'h00, 32'h00000013);

    do_reset();
    check_flags("after_reset_from_err", 4'b1001);
    apply_stimulus(1'b1, 8'h00);
    check_flags("hdr0_done", 4'b0100);
    check_instr("hdr0_no_write", 8'h00, 32'h00000013);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_flags("async_reset_from_done", 4'b1001);
    @(negedge clk);
    rst = 1'b1;

    apply_stimulus(1'b1, 8'h40);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        repeat (5) apply_stimulus(1'b0, 8'hEE);
        check_flags("gap_hold", 4'b1001);
      end
      if (i == 255) begin
        check_flags("before_last_byte", 4'b1001);
      end
      apply_stimulus(1'b1, byte_of(i));
    end
    check_flags("n64_done", 4'b0100);
    check_instr("n64_wrap_ff", 8'hFF, 32'h332211AA);
    check_instr("n64_wrap_fe", 8'hFE, {8'h22, 8'h11, 8'hAA, byte_of(254)});
    check_instr("n64_pc0", 8'h00, full_word(0));
    check_instr("n64_gap_word", 8'h64, full_word(100));

    do_reset();
    apply_stimulus(1'b1, 8'h01);
    apply_stimulus(1'b1, 8'h01);
    apply_stimulus(1'b1, 8'h02);
    apply_stimulus(1'b1, 8'h03);
    do_reset();
    check_flags("midload_reset", 4'b1001);
    apply_stimulus(1'b1, 8'h01);
    apply_stimulus(1'b1, 8'hEF);
    apply_stimulus(1'b1, 8'hBE);
    apply_stimulus(1'b1, 8'hAD);
    check_flags("reload_not_done", 4'b1001);
    apply_stimulus(1'b1, 8'hDE);
    check_flags("reload_done", 4'b0100);
    check_instr("reload_pc0", 8'h00, 32'hDEADBEEF);
    check_instr("reload_pc4_intact", 8'h04, full_word(4));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
